// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquads sharing one multiplier-accumulator.
// Runtime coefficients, valid/ready input, saturating output, bypass, clear.
module iir_biquad_cascade #(
    parameter int SECTIONS    = 2,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int COEFF_WIDTH = 16,
    parameter int Q           = 14,
    parameter int PRECISION   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [X_WIDTH-1:0]     x,
    input  logic                          bypass,
    input  logic                          clear_state,
    input  logic                          coeff_we,
    input  logic [$clog2(5*SECTIONS)-1:0] coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    output logic                          m_valid,
    output logic signed [Y_WIDTH-1:0]     y,
    output logic                          sat
);

    localparam int NC = 5 * SECTIONS;
    localparam int AW = $clog2(NC);
    localparam int KW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

    localparam logic signed [PRECISION-1:0] YMAX =
        PRECISION'(2 ** (Y_WIDTH - 1) - 1);
    localparam logic signed [PRECISION-1:0] YMIN = ~YMAX;
    localparam logic signed [COEFF_WIDTH-1:0] B0_ONE = COEFF_WIDTH'(2 ** Q);

    typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

    state_t                         state;
    logic [KW-1:0]                  k;
    logic [2:0]                     i;
    logic                           pend;
    logic                           sat_run;
    logic signed [Y_WIDTH-1:0]      cur;
    logic signed [PRECISION-1:0]    acc;
    logic signed [COEFF_WIDTH-1:0]  coef [NC];
    logic signed [Y_WIDTH-1:0]      u1 [SECTIONS];
    logic signed [Y_WIDTH-1:0]      u2 [SECTIONS];
    logic signed [Y_WIDTH-1:0]      v1 [SECTIONS];
    logic signed [Y_WIDTH-1:0]      v2 [SECTIONS];

    logic [AW-1:0]                  caddr;
    logic signed [COEFF_WIDTH-1:0]  c_sel;
    logic signed [Y_WIDTH-1:0]      op;
    logic signed [PRECISION-1:0]    prod;
    logic signed [PRECISION-1:0]    base;
    logic signed [PRECISION-1:0]    shr;
    logic signed [PRECISION-1:0]    xp;
    logic signed [Y_WIDTH-1:0]      v_new;
    logic                           v_ovf;

    function automatic logic signed [Y_WIDTH-1:0] clip(
        input logic signed [PRECISION-1:0] a
    );
        if (a > YMAX)      clip = YMAX[Y_WIDTH-1:0];
        else if (a < YMIN) clip = YMIN[Y_WIDTH-1:0];
        else               clip = a[Y_WIDTH-1:0];
    endfunction

    function automatic logic ovr(input logic signed [PRECISION-1:0] a);
        ovr = (a > YMAX) || (a < YMIN);
    endfunction

    assign s_ready = (state == IDLE) && !clear_state;

    // Operand select, product and the shift/clamp of the finished sum
    always_comb begin
        caddr = AW'(int'(k) * 5 + int'(i));
        c_sel = coef[caddr];
        op    = cur;
        unique case (i)
            3'd0:    op = cur;
            3'd1:    op = u1[k];
            3'd2:    op = u2[k];
            3'd3:    op = v1[k];
            default: op = v2[k];
        endcase
        prod  = PRECISION'(c_sel) * PRECISION'(op);
        base  = (i == 3'd0) ? '0 : acc;
        shr   = acc >>> Q;
        v_new = clip(shr);
        v_ovf = ovr(shr);
        xp    = PRECISION'(x);
    end

    // Sequencer: one MAC per cycle, writeback per section, one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            i       <= '0;
            pend    <= 1'b0;
            sat_run <= 1'b0;
            cur     <= '0;
            acc     <= '0;
            m_valid <= 1'b0;
            y       <= '0;
            sat     <= 1'b0;
            for (int n = 0; n < NC; n++)
                coef[n] <= (n % 5 == 0) ? B0_ONE : '0;
            for (int s = 0; s < SECTIONS; s++) begin
                u1[s] <= '0;
                u2[s] <= '0;
                v1[s] <= '0;
                v2[s] <= '0;
            end
        end else begin
            m_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (coeff_we && int'(coeff_addr) < NC)
                        coef[coeff_addr] <= coeff_data;
                    if (clear_state) begin
                        for (int s = 0; s < SECTIONS; s++) begin
                            u1[s] <= '0;
                            u2[s] <= '0;
                            v1[s] <= '0;
                            v2[s] <= '0;
                        end
                    end else if (s_valid) begin
                        cur     <= clip(xp);
                        sat_run <= ovr(xp);
                        k       <= '0;
                        i       <= '0;
                        if (bypass) begin
                            pend  <= 1'b1;
                            state <= OUT;
                        end else begin
                            state <= MAC;
                        end
                    end
                end
                MAC: begin
                    if (i >= 3'd3) acc <= base - prod;
                    else           acc <= base + prod;
                    if (i == 3'd4) state <= WB;
                    else           i <= i + 3'd1;
                end
                WB: begin
                    u2[k]   <= u1[k];
                    u1[k]   <= cur;
                    v2[k]   <= v1[k];
                    v1[k]   <= v_new;
                    cur     <= v_new;
                    i       <= '0;
                    sat_run <= sat_run | v_ovf;
                    if (int'(k) == SECTIONS - 1) begin
                        m_valid <= 1'b1;
                        y       <= v_new;
                        sat     <= sat_run | v_ovf;
                        pend    <= 1'b0;
                        state   <= OUT;
                    end else begin
                        k     <= k + 1'b1;
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (pend) begin
                        m_valid <= 1'b1;
                        y       <= cur;
                        sat     <= sat_run;
                        pend    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
